iob_vexriscv_bus_bridge: RTL and testbench
==========================================

// Module: iob_vexriscv_bus_bridge
// PURPOSE
//  One-channel bridge from a VexRiscv simple cmd/rsp bus (iBus or dBus) to the IOb native bus.
//  Adds real flow control, a DEPTH-entry command queue and size/alignment checking.
//  Adds per-mode boot address remapping and in-order read responses.
//  The core wrapper instantiates it twice: MODE=1 for the instruction bus, MODE=2 for the data bus.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width; 32 or 64; STRB_W=DATA_W/8, OFF_W=$clog2(STRB_W)
//  DEPTH   2   command queue entries; power of 2, >=2
//  MODE    0   0=no remap; 1=ibus: addr[ADDR_W-1]=~boot; 2=dbus: addr[ADDR_W-1]=(addr[E_BIT]^~boot)&~addr[P_BIT]
//  E_BIT   31  extmem select bit (MODE=2)
//  P_BIT   30  peripheral select bit (MODE=2)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  boot           in   1       boot status, sampled at command accept
//  cpu_cmd_valid  in   1       core command valid
//  cpu_cmd_ready  out  1       queue not full
//  cpu_cmd_wr     in   1       1=write (tie 0 for MODE=1)
//  cpu_cmd_addr   in   ADDR_W  byte address / pc
//  cpu_cmd_wdata  in   DATA_W  write data
//  cpu_cmd_size   in   2       log2 bytes: 0=1B 1=2B 2=4B 3=8B
//  cpu_rsp_valid  out  1       one-cycle response pulse (core has no rsp back-pressure)
//  cpu_rsp_data   out  DATA_W  read data (0 on error)
//  cpu_rsp_error  out  1       qualifies cpu_rsp_valid
//  iob_valid      out  1       IOb request valid, held until iob_ready
//  iob_addr       out  ADDR_W  remapped address
//  iob_wdata      out  DATA_W  write data
//  iob_wstrb      out  STRB_W  byte strobes; 0 for reads
//  iob_rdata      in   DATA_W  read data, valid with iob_ready
//  iob_ready      in   1       transaction done pulse
//  err_cnt        out  8       saturating count of rejected commands
// BEHAVIOUR
//  Reset: all outputs 0 except cpu_cmd_ready=1 the cycle after rst deasserts; queue emptied.
//  Accept: cpu_cmd_valid&cpu_cmd_ready pushes {wr,remapped addr,wdata,strb,err}; ready=!full.
//  Strobe: ((1<<(1<<size))-1) << addr[OFF_W-1:0], truncated to STRB_W.
//  err=1 if (1<<size)>STRB_W or addr[OFF_W-1:0] is not a multiple of (1<<size).
//  Full: ready low; a pop while full raises ready next cycle (no same-cycle push into freed slot).
//  FSM states IDLE, ISSUE, ERR; evaluated on the queue head:
//   IDLE : head empty -> IDLE; head.err -> ERR; else -> ISSUE with iob_valid=1 the next cycle.
//   ISSUE: iob_valid=1; addr/wdata/wstrb stable until iob_ready.
//    On iob_ready: pop. If read, next cycle cpu_rsp_valid=1, data=iob_rdata, error=0.
//    Write: no core response. Then next head: err->ERR, valid->ISSUE (back-to-back), empty->IDLE.
//   ERR  : 1 cycle, no IOb traffic; pop, err_cnt+=1 (saturate 255).
//    Read: cpu_rsp_valid=1, error=1, data=0 next cycle. Write: silently dropped. Exit as ISSUE.
//  Latency: accept in cycle N -> iob_valid earliest N+1 -> cpu_rsp_valid cycle after iob_ready.
//  Ordering: responses strictly in command order; at most one IOb transaction in flight.
//  Same-cycle push and pop (not full) legal; occupancy unchanged; head/tail pointers wrap mod DEPTH.
//  iob_ready while iob_valid=0 is ignored.
//  Reset mid-transaction: in-flight IOb access abandoned, iob_valid=0 after the rst edge, no rsp emitted.
// STRUCTURE
//  Shared package iob_vexriscv_pkg: SIZE_B/H/W/D encodings, MODE_NONE/IBUS/DBUS, FSM state enum.
//  Package also holds the strobe-generation function.
//  One sub-module: iob_vexriscv_cmd_fifo (register FIFO; push/pop/full/empty; width and DEPTH parameters).
// TESTING
//  1 Read, DATA_W=32, MODE=0: addr 0x100 size 2, iob_ready 2 cycles later with 0xCAFEF00D
//    -> wstrb 0, rsp 0xCAFEF00D next cycle, error 0.
//  2 Writes: byte addr 0x203 -> wstrb 4'b1000; half addr 0x202 -> 4'b1100. No cpu_rsp_valid.
//  3 Misaligned: word read at 0x102 -> no iob_valid, rsp error=1 data 0, err_cnt=1.
//    Size 3 write at DATA_W=32 -> dropped, err_cnt=2.
//  4 Back-pressure, DEPTH=2, iob_ready held low: 2 accepted, ready=0 on third.
//    Release -> queue drains in order, ready returns, responses in order.
//  5 Remap: MODE=2, boot=0, addr 0x8000_0010 -> iob_addr 0x0000_0010 (E xor ~boot).
//    P_BIT set -> msb 0. MODE=1, boot=0 -> msb 1.
//  6 rst asserted during ISSUE: iob_valid=0 next cycle, queue empty, no rsp.
//    Late iob_ready ignored. Next read completes normally.

Source files
------------

// File: rtl/iob_vexriscv_pkg.sv
// Shared encodings, FSM state type and strobe helper for the VexRiscv-to-IOb bridge.
package iob_vexriscv_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam int unsigned MODE_NONE = 0;
   localparam int unsigned MODE_IBUS = 1;
   localparam int unsigned MODE_DBUS = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   // Byte-lane mask for an access of 2**size bytes at byte offset off (8 lanes max, caller truncates)
   function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] off);
      logic [15:0] m;
      m = (16'd1 << (4'd1 << size)) - 16'd1;
      m = m << off;
      return m[7:0];
   endfunction

endpackage

// File: rtl/iob_vexriscv_cmd_fifo.sv
// Register FIFO holding accepted commands; exposes the head entry and the flag of the entry behind it.
module iob_vexriscv_cmd_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     push_tag,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [W-1:0]             head,
   output logic                     head_tag,
   output logic                     next_tag
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [DEPTH-1:0] tag;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_nxt;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign level    = count;
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign rd_nxt   = rd_ptr + PTR_W'(1);
   assign head     = mem[rd_ptr];
   assign head_tag = tag[rd_ptr];
   assign next_tag = tag[rd_nxt];

   // Storage and pointers; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         tag    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            tag[wr_ptr] <= push_tag;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_nxt;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/iob_vexriscv_bus_bridge.sv
// VexRiscv cmd/rsp to IOb native bridge: queued commands, size/alignment checks, boot remap, in-order responses.
module iob_vexriscv_bus_bridge
   import iob_vexriscv_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned MODE   = 0,
   parameter int unsigned E_BIT  = 31,
   parameter int unsigned P_BIT  = 30
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                boot,
   input  logic                cpu_cmd_valid,
   output logic                cpu_cmd_ready,
   input  logic                cpu_cmd_wr,
   input  logic [ADDR_W-1:0]   cpu_cmd_addr,
   input  logic [DATA_W-1:0]   cpu_cmd_wdata,
   input  logic [1:0]          cpu_cmd_size,
   output logic                cpu_rsp_valid,
   output logic [DATA_W-1:0]   cpu_rsp_data,
   output logic                cpu_rsp_error,
   output logic                iob_valid,
   output logic [ADDR_W-1:0]   iob_addr,
   output logic [DATA_W-1:0]   iob_wdata,
   output logic [DATA_W/8-1:0] iob_wstrb,
   input  logic [DATA_W-1:0]   iob_rdata,
   input  logic                iob_ready,
   output logic [7:0]          err_cnt
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned ENT_W  = 1 + STRB_W + ADDR_W + DATA_W;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   state_t             state;
   state_t             state_n;
   state_t             follow_st;

   logic [ADDR_W-1:0]  addr_rm;
   logic [3:0]         nbytes;
   logic               size_bad;
   logic               align_bad;
   logic               push;
   logic               push_err;
   logic [STRB_W-1:0]  push_strb;
   logic [ENT_W-1:0]   push_data;
   logic               pop;

   logic               full;
   logic               empty;
   logic [CNT_W-1:0]   level;
   logic [CNT_W-1:0]   level_n;
   logic [ENT_W-1:0]   head;
   logic               head_err;
   logic               next_err;
   logic               h_wr;

   // Boot remap of the address msb, chosen per bus flavour
   always_comb begin
      addr_rm = cpu_cmd_addr;
      if (MODE == MODE_IBUS) begin
         addr_rm[ADDR_W-1] = ~boot;
      end else if (MODE == MODE_DBUS) begin
         addr_rm[ADDR_W-1] = (cpu_cmd_addr[E_BIT] ^ ~boot) & ~cpu_cmd_addr[P_BIT];
      end
   end

   // Size/alignment check and strobe build for the incoming command
   always_comb begin
      nbytes    = 4'd1 << cpu_cmd_size;
      size_bad  = 32'(nbytes) > STRB_W;
      align_bad = (3'(cpu_cmd_addr[OFF_W-1:0]) & 3'(nbytes - 4'd1)) != 3'd0;
      push_err  = size_bad | align_bad;
      push_strb = cpu_cmd_wr ? STRB_W'(strb_gen(cpu_cmd_size, 3'(cpu_cmd_addr[OFF_W-1:0])))
                             : '0;
      push_data = {cpu_cmd_wr, push_strb, addr_rm, cpu_cmd_wdata};
   end

   assign push = cpu_cmd_valid & cpu_cmd_ready;

   iob_vexriscv_cmd_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .push_tag  (push_err),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .head      (head),
      .head_tag  (head_err),
      .next_tag  (next_err)
   );

   assign h_wr      = head[ENT_W-1];
   assign iob_wstrb = head[ENT_W-2 -: STRB_W];
   assign iob_addr  = head[DATA_W +: ADDR_W];
   assign iob_wdata = head[DATA_W-1:0];
   assign iob_valid = (state == ST_ISSUE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Next state and pop; after a pop the entry behind the head (or a same-cycle push) decides
   always_comb begin
      state_n   = state;
      pop       = 1'b0;
      follow_st = ST_IDLE;
      if (level >= CNT_W'(2)) follow_st = next_err ? ST_ERR : ST_ISSUE;
      else if (push)          follow_st = push_err ? ST_ERR : ST_ISSUE;
      case (state)
         ST_IDLE: begin
            if (!empty)    state_n = head_err ? ST_ERR : ST_ISSUE;
            else if (push) state_n = push_err ? ST_ERR : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (iob_ready) begin
               pop     = 1'b1;
               state_n = follow_st;
            end
         end
         ST_ERR: begin
            pop     = 1'b1;
            state_n = follow_st;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Ready tracks next-cycle occupancy; a slot freed while full is reusable only from the next cycle
   assign level_n = level + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (rst) cpu_cmd_ready <= 1'b0;
      else     cpu_cmd_ready <= (level_n != CNT_W'(DEPTH));
   end

   // Core response pulse and rejected-command counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rsp_valid <= 1'b0;
         cpu_rsp_data  <= '0;
         cpu_rsp_error <= 1'b0;
         err_cnt       <= '0;
      end else begin
         cpu_rsp_valid <= 1'b0;
         cpu_rsp_error <= 1'b0;
         if (state == ST_ISSUE && iob_ready && !h_wr) begin
            cpu_rsp_valid <= 1'b1;
            cpu_rsp_data  <= iob_rdata;
         end else if (state == ST_ERR) begin
            if (!h_wr) begin
               cpu_rsp_valid <= 1'b1;
               cpu_rsp_data  <= '0;
               cpu_rsp_error <= 1'b1;
            end
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_iob_vexriscv_bus_bridge.sv
// Directed bench for the VexRiscv-to-IOb bridge; three instances share stimulus to cover the remap modes.
module tb_iob_vexriscv_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        boot;
   logic        cpu_cmd_valid;
   logic        cpu_cmd_wr;
   logic [31:0] cpu_cmd_addr;
   logic [31:0] cpu_cmd_wdata;
   logic [1:0]  cpu_cmd_size;
   logic [31:0] iob_rdata;
   logic        iob_ready;

   logic        u0_cmd_ready, u0_rsp_valid, u0_rsp_error, u0_iob_valid;
   logic [31:0] u0_rsp_data, u0_iob_addr, u0_iob_wdata;
   logic [3:0]  u0_iob_wstrb;
   logic [7:0]  u0_err_cnt;

   logic        u1_cmd_ready, u1_rsp_valid, u1_rsp_error, u1_iob_valid;
   logic [31:0] u1_rsp_data, u1_iob_addr, u1_iob_wdata;
   logic [3:0]  u1_iob_wstrb;
   logic [7:0]  u1_err_cnt;

   logic        u2_cmd_ready, u2_rsp_valid, u2_rsp_error, u2_iob_valid;
   logic [31:0] u2_rsp_data, u2_iob_addr, u2_iob_wdata;
   logic [3:0]  u2_iob_wstrb;
   logic [7:0]  u2_err_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iob_vexriscv_bus_bridge #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .boot(boot),
      .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(u0_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
      .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_wdata(cpu_cmd_wdata), .cpu_cmd_size(cpu_cmd_size),
      .cpu_rsp_valid(u0_rsp_valid), .cpu_rsp_data(u0_rsp_data), .cpu_rsp_error(u0_rsp_error),
      .iob_valid(u0_iob_valid), .iob_addr(u0_iob_addr), .iob_wdata(u0_iob_wdata),
      .iob_wstrb(u0_iob_wstrb), .iob_rdata(iob_rdata), .iob_ready(iob_ready),
      .err_cnt(u0_err_cnt)
   );

   iob_vexriscv_bus_bridge #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .boot(boot),
      .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(u1_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
      .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_wdata(cpu_cmd_wdata), .cpu_cmd_size(cpu_cmd_size),
      .cpu_rsp_valid(u1_rsp_valid), .cpu_rsp_data(u1_rsp_data), .cpu_rsp_error(u1_rsp_error),
      .iob_valid(u1_iob_valid), .iob_addr(u1_iob_addr), .iob_wdata(u1_iob_wdata),
      .iob_wstrb(u1_iob_wstrb), .iob_rdata(iob_rdata), .iob_ready(iob_ready),
      .err_cnt(u1_err_cnt)
   );

   iob_vexriscv_bus_bridge #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .MODE(2), .E_BIT(31), .P_BIT(30)) u2 (
      .clk(clk), .rst(rst), .boot(boot),
      .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(u2_cmd_ready), .cpu_cmd_wr(cpu_cmd_wr),
      .cpu_cmd_addr(cpu_cmd_addr), .cpu_cmd_wdata(cpu_cmd_wdata), .cpu_cmd_size(cpu_cmd_size),
      .cpu_rsp_valid(u2_rsp_valid), .cpu_rsp_data(u2_rsp_data), .cpu_rsp_error(u2_rsp_error),
      .iob_valid(u2_iob_valid), .iob_addr(u2_iob_addr), .iob_wdata(u2_iob_wdata),
      .iob_wstrb(u2_iob_wstrb), .iob_rdata(iob_rdata), .iob_ready(iob_ready),
      .err_cnt(u2_err_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command, wait (bounded) for ready, let it be accepted on the next edge
   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz);
      int n = 0;
      cpu_cmd_valid = 1'b1;
      cpu_cmd_wr    = wr;
      cpu_cmd_addr  = addr;
      cpu_cmd_wdata = wd;
      cpu_cmd_size  = sz;
      while (!u0_cmd_ready && n < 20) begin
         tick();
         n++;
      end
      chk("cmd_accept", 64'(u0_cmd_ready), 64'd1);
      tick();
      cpu_cmd_valid = 1'b0;
      cpu_cmd_wr    = 1'b0;
   endtask

   // One-cycle iob_ready completion pulse
   task automatic pulse(input logic [31:0] rd);
      iob_rdata = rd;
      iob_ready = 1'b1;
      tick();
      iob_ready = 1'b0;
      iob_rdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; boot = 1'b0;
      cpu_cmd_valid = 1'b0; cpu_cmd_wr = 1'b0; cpu_cmd_addr = '0;
      cpu_cmd_wdata = '0; cpu_cmd_size = '0;
      iob_rdata = '0; iob_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_iob_valid", 64'(u0_iob_valid), 64'd0);
      chk("rst_rsp_valid", 64'(u0_rsp_valid), 64'd0);
      chk("rst_err_cnt",   64'(u0_err_cnt),   64'd0);
      chk("rst_ready_low", 64'(u0_cmd_ready), 64'd0);
      chk("rst_iob_addr",  64'(u0_iob_addr),  64'd0);
      rst = 1'b0;
      tick();
      chk("rst_ready_up",  64'(u0_cmd_ready), 64'd1);

      // 1: aligned word read
      do_cmd(1'b0, 32'h0000_0100, 32'h0, 2'd2);
      chk("t1_iob_valid", 64'(u0_iob_valid), 64'd1);
      chk("t1_iob_addr",  64'(u0_iob_addr),  64'h100);
      chk("t1_wstrb",     64'(u0_iob_wstrb), 64'h0);
      tick();
      chk("t1_hold_valid", 64'(u0_iob_valid), 64'd1);
      chk("t1_hold_addr",  64'(u0_iob_addr),  64'h100);
      chk("t1_no_early_rsp", 64'(u0_rsp_valid), 64'd0);
      pulse(32'hCAFE_F00D);
      chk("t1_rsp_valid", 64'(u0_rsp_valid), 64'd1);
      chk("t1_rsp_data",  64'(u0_rsp_data),  64'hCAFE_F00D);
      chk("t1_rsp_error", 64'(u0_rsp_error), 64'd0);
      chk("t1_iob_done",  64'(u0_iob_valid), 64'd0);
      tick();
      chk("t1_rsp_pulse", 64'(u0_rsp_valid), 64'd0);

      // 2: byte and halfword writes
      do_cmd(1'b1, 32'h0000_0203, 32'h1122_3344, 2'd0);
      chk("t2b_valid", 64'(u0_iob_valid), 64'd1);
      chk("t2b_wstrb", 64'(u0_iob_wstrb), 64'h8);
      chk("t2b_wdata", 64'(u0_iob_wdata), 64'h1122_3344);
      pulse(32'h0);
      chk("t2b_no_rsp", 64'(u0_rsp_valid), 64'd0);
      do_cmd(1'b1, 32'h0000_0202, 32'hAABB_CCDD, 2'd1);
      chk("t2h_wstrb", 64'(u0_iob_wstrb), 64'hC);
      chk("t2h_addr",  64'(u0_iob_addr),  64'h202);
      pulse(32'h0);
      chk("t2h_no_rsp", 64'(u0_rsp_valid), 64'd0);
      tick();
      chk("t2_idle", 64'(u0_iob_valid), 64'd0);

      // 3: misaligned read and oversize write are rejected
      do_cmd(1'b0, 32'h0000_0102, 32'h0, 2'd2);
      chk("t3a_no_iob", 64'(u0_iob_valid), 64'd0);
      tick();
      chk("t3a_rsp_valid", 64'(u0_rsp_valid), 64'd1);
      chk("t3a_rsp_error", 64'(u0_rsp_error), 64'd1);
      chk("t3a_rsp_data",  64'(u0_rsp_data),  64'd0);
      chk("t3a_err_cnt",   64'(u0_err_cnt),   64'd1);
      chk("t3a_no_iob2",   64'(u0_iob_valid), 64'd0);
      do_cmd(1'b1, 32'h0000_0200, 32'h5555_AAAA, 2'd3);
      chk("t3b_no_iob", 64'(u0_iob_valid), 64'd0);
      tick();
      chk("t3b_no_rsp",  64'(u0_rsp_valid), 64'd0);
      chk("t3b_err_cnt", 64'(u0_err_cnt),   64'd2);

      // 4: back-pressure with iob_ready held low, then in-order drain
      cpu_cmd_valid = 1'b1; cpu_cmd_wr = 1'b0; cpu_cmd_size = 2'd2;
      cpu_cmd_addr = 32'h10;
      chk("t4_ready0", 64'(u0_cmd_ready), 64'd1);
      tick();
      cpu_cmd_addr = 32'h14;
      chk("t4_ready1", 64'(u0_cmd_ready), 64'd1);
      tick();
      cpu_cmd_addr = 32'h18;
      chk("t4_full_ready", 64'(u0_cmd_ready), 64'd0);
      chk("t4_head_addr",  64'(u0_iob_addr),  64'h10);
      tick();
      chk("t4_still_full", 64'(u0_cmd_ready), 64'd0);
      chk("t4_still_head", 64'(u0_iob_addr),  64'h10);
      iob_ready = 1'b1; iob_rdata = 32'hA1;
      tick();
      chk("t4_rsp1",       64'(u0_rsp_data),  64'hA1);
      chk("t4_rsp1_valid", 64'(u0_rsp_valid), 64'd1);
      chk("t4_ready_back", 64'(u0_cmd_ready), 64'd1);
      chk("t4_addr2",      64'(u0_iob_addr),  64'h14);
      iob_rdata = 32'hA2;
      tick();
      cpu_cmd_valid = 1'b0;
      chk("t4_rsp2",   64'(u0_rsp_data),  64'hA2);
      chk("t4_addr3",  64'(u0_iob_addr),  64'h18);
      chk("t4_valid3", 64'(u0_iob_valid), 64'd1);
      iob_rdata = 32'hA3;
      tick();
      iob_ready = 1'b0; iob_rdata = '0;
      chk("t4_rsp3",   64'(u0_rsp_data),  64'hA3);
      chk("t4_rsp3_v", 64'(u0_rsp_valid), 64'd1);
      chk("t4_drained", 64'(u0_iob_valid), 64'd0);
      tick();
      chk("t4_quiet", 64'(u0_rsp_valid), 64'd0);

      // 5: boot remap in ibus and dbus modes (boot=0)
      boot = 1'b0;
      do_cmd(1'b0, 32'h8000_0010, 32'h0, 2'd2);
      chk("t5a_dbus", 64'(u2_iob_addr), 64'h0000_0010);
      chk("t5a_none", 64'(u0_iob_addr), 64'h8000_0010);
      pulse(32'h1);
      do_cmd(1'b0, 32'h0000_0040, 32'h0, 2'd2);
      chk("t5b_ibus", 64'(u1_iob_addr), 64'h8000_0040);
      chk("t5b_dbus", 64'(u2_iob_addr), 64'h8000_0040);
      pulse(32'h2);
      do_cmd(1'b0, 32'h4000_0020, 32'h0, 2'd2);
      chk("t5c_dbus_periph", 64'(u2_iob_addr), 64'h4000_0020);
      chk("t5c_ibus",        64'(u1_iob_addr), 64'hC000_0020);
      pulse(32'h3);
      tick();

      // 6: reset during an outstanding access
      do_cmd(1'b0, 32'h0000_0300, 32'h0, 2'd2);
      chk("t6_issue", 64'(u0_iob_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_abandon",   64'(u0_iob_valid), 64'd0);
      chk("t6_no_rsp",    64'(u0_rsp_valid), 64'd0);
      chk("t6_err_clear", 64'(u0_err_cnt),   64'd0);
      tick();
      pulse(32'hDEAD_BEEF);
      chk("t6_late_ready_rsp", 64'(u0_rsp_valid), 64'd0);
      chk("t6_late_ready_iob", 64'(u0_iob_valid), 64'd0);
      do_cmd(1'b0, 32'h0000_0304, 32'h0, 2'd2);
      chk("t6_next_addr", 64'(u0_iob_addr), 64'h304);
      pulse(32'h1234_5678);
      chk("t6_next_rsp_v", 64'(u0_rsp_valid), 64'd1);
      chk("t6_next_rsp",   64'(u0_rsp_data),  64'h1234_5678);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
